instr_fetch: RTL



---
 rtl/instr_fetch_pkg.sv | 24 ++
 rtl/instr_fetch_if.sv | 31 +++
 rtl/instr_fetch_fetch_buffer.sv | 62 ++++++
 rtl/instr_fetch.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   PC_W / IR_W : program counter and instruction word widths
//   TIMEOUT     : number of waiting cycles before a memory request is abandoned
//   CNT_W       : width of the timeout counter
//   fetch_state_e : fetch FSM encoding (also exported on the debug port)
package instr_fetch_pkg;

  localparam int PC_W    = 8;
  localparam int IR_W    = 6;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  // PC arithmetic wraps naturally at PC_W bits (8'hFF + 1 -> 8'h00).
  function automatic logic [PC_W-1:0] pc_plus1(input logic [PC_W-1:0] pc_val);
    return pc_val + PC_W'(1);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory bus between the fetch unit (master) and memory (slave).
//   mem_addr  : word address, held stable while mem_rd is high
//   mem_rd    : read request, held high until the response strobe arrives
//   mem_data  : instruction word, meaningful only while mem_valid is high
//   mem_valid : one-cycle response strobe, 1..N cycles after the request
// Handshake: a request is outstanding from the cycle mem_rd rises until the
// edge on which mem_valid is sampled high; the master drops mem_rd on that
// same edge. mem_valid seen with no outstanding request is ignored.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic [PC_W-1:0] mem_addr;
  logic            mem_rd;
  logic [IR_W-1:0] mem_data;
  logic            mem_valid;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_data,
    input  mem_valid
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_data,
    output mem_valid
  );

endinterface

// File: rtl/instr_fetch_fetch_buffer.sv
// One-entry prefetch buffer holding an instruction word and the address it
// was fetched from.
//   clk, reset   : clock, synchronous active-high reset
//   wr_i         : capture wr_data_i tagged with wr_addr_i
//   rd_i         : entry consumed (invalidate)
//   flush_i      : discard entry; wins over write and read
//   cmp_addr_i   : address compared against the stored tag
//   data_o       : stored word
//   hit_o        : entry valid and tag equals cmp_addr_i
//   valid_nxt_o  : valid flag as it will be after this edge
module fetch_buffer
  import instr_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_i,
  input  logic [IR_W-1:0] wr_data_i,
  input  logic [PC_W-1:0] wr_addr_i,
  input  logic            rd_i,
  input  logic            flush_i,
  input  logic [PC_W-1:0] cmp_addr_i,
  output logic [IR_W-1:0] data_o,
  output logic            hit_o,
  output logic            valid_nxt_o
);

  logic            valid_q, valid_d;
  logic [IR_W-1:0] data_q, data_d;
  logic [PC_W-1:0] addr_q, addr_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (wr_i) begin
      valid_d = 1'b1;
      data_d  = wr_data_i;
      addr_d  = wr_addr_i;
    end else if (rd_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  assign data_o      = data_q;
  assign hit_o       = valid_q && (addr_q == cmp_addr_i);
  assign valid_nxt_o = valid_d;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: keeps the PC, prefetches the word at PC into a
// one-entry buffer and serves control-unit IR loads from it, stalling the
// control unit when the word is not yet available.
//   clk, reset   : clock, synchronous active-high reset
//   LDIR         : load IR from the word at the current PC
//   PC_INC       : PC <= PC + 1 (wraps)
//   pc_load      : PC <= pc_in, discards the prefetch (wins over PC_INC)
//   pc_in        : jump target
//   mem          : instruction memory bus (master side)
//   IR, ir_valid : instruction register and its valid flag
//   stall        : an IR load is pending
//   pc           : current PC
//   fetch_err    : sticky memory-timeout flag, cleared only by reset
//   dbg_state_o  : fetch FSM state
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            LDIR,
  input  logic            PC_INC,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_in,
  instr_fetch_if.master   mem,
  output logic [IR_W-1:0] IR,
  output logic            ir_valid,
  output logic            stall,
  output logic [PC_W-1:0] pc,
  output logic            fetch_err,
  output fetch_state_e    dbg_state_o
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            ir_valid_q, ir_valid_d;
  logic            stall_q, stall_d;
  logic            ld_pend_q, ld_pend_d;
  logic [PC_W-1:0] ld_addr_q, ld_addr_d;
  logic            mem_rd_q, mem_rd_d;
  logic [PC_W-1:0] mem_addr_q, mem_addr_d;
  logic [PC_W-1:0] tag_q, tag_d;
  logic            fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            buf_wr, buf_rd, buf_flush;
  logic            buf_hit, buf_valid_nxt;
  logic [IR_W-1:0] buf_data;
  logic            rsp_ok;
  logic            want_load;
  logic [PC_W-1:0] want_addr;
  logic [PC_W-1:0] fetch_addr;
  logic            timeout;

  fetch_buffer u_buf (
    .clk         (clk),
    .reset       (reset),
    .wr_i        (buf_wr),
    .wr_data_i   (mem.mem_data),
    .wr_addr_i   (tag_q),
    .rd_i        (buf_rd),
    .flush_i     (buf_flush),
    .cmp_addr_i  (pc_q),
    .data_o      (buf_data),
    .hit_o       (buf_hit),
    .valid_nxt_o (buf_valid_nxt)
  );

  // PC update, IR loads and prefetch-buffer control.
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    ld_pend_d  = ld_pend_q;
    ld_addr_d  = ld_addr_q;
    stall_d    = stall_q;
    buf_wr     = 1'b0;
    buf_rd     = 1'b0;
    buf_flush  = 1'b0;

    // A response is usable only for a live (not jumped-away) WAIT request.
    rsp_ok    = (state_q == S_WAIT) && mem.mem_valid && !pc_load;
    want_load = ld_pend_q || LDIR;
    // A jump retargets a new or pending load to the jump target; otherwise a
    // new load uses the PC before any same-cycle increment.
    if (pc_load)        want_addr = pc_in;
    else if (ld_pend_q) want_addr = ld_addr_q;
    else                want_addr = pc_q;

    if (pc_load) begin
      pc_d      = pc_in;
      buf_flush = 1'b1;
    end else if (PC_INC) begin
      pc_d = pc_plus1(pc_q);
    end

    if (want_load) begin
      if (!ld_pend_q && !pc_load && buf_hit) begin
        ir_d       = buf_data;
        ir_valid_d = 1'b1;
        buf_rd     = 1'b1;
      end else if (rsp_ok && (tag_q == want_addr)) begin
        // Bypass: the response goes straight to IR, buffer stays empty.
        ir_d       = mem.mem_data;
        ir_valid_d = 1'b1;
        ld_pend_d  = 1'b0;
        stall_d    = 1'b0;
      end else begin
        ld_pend_d = 1'b1;
        ld_addr_d = want_addr;
        stall_d   = 1'b1;
        buf_flush = 1'b1;
      end
    end

    // With a load waiting on another address, a non-matching response is
    // dropped so IDLE immediately refetches the address the load needs.
    if (rsp_ok && !want_load) buf_wr = 1'b1;
  end

  // Fetch FSM: issues requests, waits for responses, handles timeouts.
  always_comb begin
    state_d     = state_q;
    mem_rd_d    = mem_rd_q;
    mem_addr_d  = mem_addr_q;
    tag_d       = tag_q;
    cnt_d       = cnt_q;
    fetch_err_d = fetch_err_q;
    fetch_addr  = ld_pend_d ? ld_addr_d : pc_d;
    timeout     = (cnt_q == TMO_LAST);

    unique case (state_q)
      S_IDLE: begin
        if (!buf_valid_nxt) begin
          state_d    = S_WAIT;
          mem_rd_d   = 1'b1;
          mem_addr_d = fetch_addr;
          tag_d      = fetch_addr;
          cnt_d      = '0;
        end
      end
      S_WAIT, S_DROP: begin
        if (mem.mem_valid) begin
          state_d  = S_IDLE;
          mem_rd_d = 1'b0;
          cnt_d    = '0;
        end else if (timeout) begin
          // mem_rd drops for one cycle; IDLE reissues on the next edge.
          state_d     = S_IDLE;
          mem_rd_d    = 1'b0;
          fetch_err_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if ((state_q == S_WAIT) && pc_load) state_d = S_DROP;
        end
      end
      default: begin
        state_d  = S_IDLE;
        mem_rd_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      stall_q     <= 1'b0;
      ld_pend_q   <= 1'b0;
      ld_addr_q   <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      tag_q       <= '0;
      fetch_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ir_valid_q  <= ir_valid_d;
      stall_q     <= stall_d;
      ld_pend_q   <= ld_pend_d;
      ld_addr_q   <= ld_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      tag_q       <= tag_d;
      fetch_err_q <= fetch_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem.mem_rd   = mem_rd_q;
  assign mem.mem_addr = mem_addr_q;
  assign IR           = ir_q;
  assign ir_valid     = ir_valid_q;
  assign stall        = stall_q;
  assign pc           = pc_q;
  assign fetch_err    = fetch_err_q;
  assign dbg_state_o  = state_q;

endmodule
